// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: program-memory read port, decoder handshake and
// branch/halt control.
//   master : the fetch unit (drives mem_addr and the instruction outputs)
//   slave  : the environment (memory, decoder, branch source)
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] literal;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  branch_valid;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  halted;

  modport master (
    output mem_addr, instr, literal, instr_pc, instr_valid, halted,
    input  mem_q, instr_ready, branch_valid, branch_target
  );

  modport slave (
    input  mem_addr, instr, literal, instr_pc, instr_valid, halted,
    output mem_q, instr_ready, branch_valid, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a registered-read program memory.
// Fetches one word per instruction (two for PUSH: opcode word + literal),
// presents it to the decoder over valid/ready, supports branch redirect and
// stops after handing off a HALT.
//   clock   : rising-edge clock, shared with the memory read clock
//   reset_n : asynchronous active-low reset
//   bus     : fetch_unit_if.master (mem_addr/mem_q, instr/literal/instr_pc,
//             instr_valid/instr_ready, branch_valid/branch_target, halted)
module fetch_unit #(
  parameter int unsigned             DATA_WIDTH   = 16,
  parameter int unsigned             ADDR_WIDTH   = 5,
  parameter int unsigned             OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] PUSH_OPCODE  = 5'b10000,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 5'b11100,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    StIssue, StCapture, StLitIssue, StLitCapture, StOut, StHalt
  } state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_fetch_ptr;
  logic [DATA_WIDTH-1:0]   r_instr;
  logic [DATA_WIDTH-1:0]   r_literal;
  logic [ADDR_WIDTH-1:0]   r_instr_pc;
  logic                    r_instr_valid;
  logic                    r_halted;

  logic [OPCODE_WIDTH-1:0] w_mem_opcode;
  logic [OPCODE_WIDTH-1:0] w_cur_opcode;
  logic [ADDR_WIDTH-1:0]   w_ptr_inc;

  assign w_mem_opcode = bus.mem_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_cur_opcode = r_instr[DATA_WIDTH-1 -: OPCODE_WIDTH];
  // Natural wrap modulo 2**ADDR_WIDTH.
  assign w_ptr_inc    = r_fetch_ptr + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIssue;
      r_fetch_ptr   <= RESET_PC;
      r_instr       <= '0;
      r_literal     <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else if (bus.branch_valid) begin
      // Redirect beats everything; an accept in the same cycle still completes
      // on the decoder side, but no HALT entry and no in-flight word survives.
      r_state       <= StIssue;
      r_fetch_ptr   <= bus.branch_target;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      unique case (r_state)
        StIssue: begin
          r_state <= StCapture;
        end
        StCapture: begin
          r_instr     <= bus.mem_q;
          r_instr_pc  <= r_fetch_ptr;
          r_fetch_ptr <= w_ptr_inc;
          if (w_mem_opcode == PUSH_OPCODE) begin
            r_state <= StLitIssue;
          end else begin
            r_state       <= StOut;
            r_instr_valid <= 1'b1;
          end
        end
        StLitIssue: begin
          r_state <= StLitCapture;
        end
        StLitCapture: begin
          r_literal     <= bus.mem_q;
          r_fetch_ptr   <= w_ptr_inc;
          r_state       <= StOut;
          r_instr_valid <= 1'b1;
        end
        StOut: begin
          if (bus.instr_ready) begin
            r_instr_valid <= 1'b0;
            if (w_cur_opcode == HALT_OPCODE) begin
              r_state  <= StHalt;
              r_halted <= 1'b1;
            end else begin
              r_state <= StIssue;
            end
          end
        end
        StHalt: begin
          r_state <= StHalt;
        end
        default: begin
          r_state       <= StIssue;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_fetch_ptr;
  assign bus.instr       = r_instr;
  assign bus.literal     = r_literal;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against a transaction-level program-walk model.
module tb_fetch_unit;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam logic [4:0] OP_PUSH = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11100;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  logic [DW-1:0] mem [0:31];

  fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read program memory.
  always @(posedge clock) bus.mem_q <= mem[bus.mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1);
  end

  // Expected accepted sequence from a straight program walk.
  logic [DW-1:0] exp_instr [$];
  logic [DW-1:0] exp_lit   [$];
  logic [AW-1:0] exp_pc    [$];

  task automatic build_expected(input logic [AW-1:0] start, input int max_n);
    logic [AW-1:0] pc;
    logic [DW-1:0] w;
    exp_instr.delete(); exp_lit.delete(); exp_pc.delete();
    pc = start;
    for (int n = 0; n < max_n; n++) begin
      w = mem[pc];
      exp_instr.push_back(w);
      exp_pc.push_back(pc);
      if (w[15:11] == OP_PUSH) begin
        exp_lit.push_back(mem[AW'(pc + 1)]);
        pc = AW'(pc + 2);
      end else begin
        exp_lit.push_back('0);
        pc = AW'(pc + 1);
      end
      if (w[15:11] == OP_HALT) break;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_reset();
    bus.instr_ready   = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    clear_mem();
    mem[0] = 16'h8800;
    hold_reset();
    release_reset();
    wait_valid(10, ok);
    // Reset mid-operation clears everything at once, no clock needed.
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.instr_valid, bus.instr, bus.literal, bus.instr_pc, bus.halted, bus.mem_addr} !== '0) begin
      bad++;
      $display("FAIL reset_async: got valid=%b instr=%h lit=%h pc=%0d halted=%b addr=%0d required all 0",
               bus.instr_valid, bus.instr, bus.literal, bus.instr_pc, bus.halted, bus.mem_addr);
    end
    repeat (2) @(negedge clock);
    release_reset();
    step();
    total++;
    if (bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge1: got valid=%b required 0", bus.instr_valid);
    end
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h8800 || bus.instr_pc !== 5'd0) begin
      bad++;
      $display("FAIL reset_edge2: got valid=%b instr=%h pc=%0d required 1/8800/0",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
  endtask

  task automatic test_push();
    clear_mem();
    mem[0] = 16'h8000;
    mem[1] = 16'h0006;
    hold_reset();
    release_reset();
    bus.instr_ready = 1'b1;
    repeat (3) step();
    total++;
    if (bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL push_early: got valid=%b after 3 edges required 0", bus.instr_valid);
    end
    step();
    total++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h8000 || bus.literal !== 16'h0006 ||
        bus.instr_pc !== 5'd0 || bus.mem_addr !== 5'd2) begin
      bad++;
      $display("FAIL push_edge4: got v=%b instr=%h lit=%h pc=%0d addr=%0d required 1/8000/0006/0/2",
               bus.instr_valid, bus.instr, bus.literal, bus.instr_pc, bus.mem_addr);
    end
  endtask

  task automatic test_program();
    logic [DW-1:0] got_i [$];
    logic [DW-1:0] got_l [$];
    logic [AW-1:0] got_p [$];
    clear_mem();
    mem[0] = 16'h8000; mem[1] = 16'h0006; mem[2] = 16'h8000;
    mem[3] = 16'h0001; mem[4] = 16'h8800; mem[5] = 16'hE000;
    build_expected(5'd0, 16);
    hold_reset();
    release_reset();
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (bus.instr_valid === 1'b1) begin
        got_i.push_back(bus.instr);
        got_l.push_back(bus.literal);
        got_p.push_back(bus.instr_pc);
      end
    end
    total++;
    if (got_i.size() != exp_instr.size()) begin
      bad++;
      $display("FAIL prog_count: got %0d accepts required %0d", got_i.size(), exp_instr.size());
    end else begin
      for (int k = 0; k < got_i.size(); k++) begin
        total++;
        if (got_i[k] !== exp_instr[k] || got_p[k] !== exp_pc[k] ||
            (exp_instr[k][15:11] == OP_PUSH && got_l[k] !== exp_lit[k])) begin
          bad++;
          $display("FAIL prog_item%0d: got %h/%h/%0d required %h/%h/%0d", k,
                   got_i[k], got_l[k], got_p[k], exp_instr[k], exp_lit[k], exp_pc[k]);
        end
      end
    end
    total++;
    if (bus.halted !== 1'b1 || bus.mem_addr !== 5'd6 || bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL prog_halt: got halted=%b addr=%0d valid=%b required 1/6/0",
               bus.halted, bus.mem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] s_i, s_l;
    logic [AW-1:0] s_p, s_a;
    clear_mem();
    mem[0] = 16'h0800; mem[1] = 16'h0801;
    hold_reset();
    release_reset();
    wait_valid(10, ok);
    s_i = bus.instr; s_l = bus.literal; s_p = bus.instr_pc; s_a = bus.mem_addr;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== s_i || bus.literal !== s_l ||
          bus.instr_pc !== s_p || bus.mem_addr !== s_a || s_i !== 16'h0800) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b %h/%h/%0d addr=%0d required 1 0800/%h/%0d addr=%0d", c,
                 bus.instr_valid, bus.instr, bus.literal, bus.instr_pc, bus.mem_addr,
                 s_l, s_p, s_a);
      end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept: got valid=%b after accept required 0", bus.instr_valid);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || bus.instr_pc !== 5'd1 || bus.instr !== 16'h0801) begin
      bad++;
      $display("FAIL bp_next: got ok=%b pc=%0d instr=%h required 1/1/0801", ok, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_branch();
    bit ok;
    clear_mem();
    mem[0] = 16'h8000; mem[1] = 16'h00AA; mem[3] = 16'h0803; mem[4] = 16'hE000;
    hold_reset();
    release_reset();
    step();
    step();
    // Now in the literal-issue cycle.
    bus.branch_valid = 1'b1;
    bus.branch_target = 5'd3;
    step();
    bus.branch_valid = 1'b0;
    total++;
    if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 5'd3) begin
      bad++;
      $display("FAIL br_redirect: got valid=%b addr=%0d required 0/3", bus.instr_valid, bus.mem_addr);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || bus.instr_pc !== 5'd3 || bus.instr !== 16'h0803 || bus.literal !== 16'h0000) begin
      bad++;
      $display("FAIL br_target: got ok=%b pc=%0d instr=%h lit=%h required 1/3/0803/0000",
               ok, bus.instr_pc, bus.instr, bus.literal);
    end
    bus.instr_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      ok = (bus.halted === 1'b1);
    end
    bus.instr_ready = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL br_halt: got halted=%b required 1", bus.halted);
    end
    bus.branch_valid = 1'b1;
    bus.branch_target = 5'd0;
    step();
    bus.branch_valid = 1'b0;
    total++;
    if (bus.halted !== 1'b0 || bus.mem_addr !== 5'd0) begin
      bad++;
      $display("FAIL br_unhalt: got halted=%b addr=%0d required 0/0", bus.halted, bus.mem_addr);
    end
    wait_valid(10, ok);
    total++;
    if (!ok || bus.instr_pc !== 5'd0 || bus.instr !== 16'h8000 || bus.literal !== 16'h00AA) begin
      bad++;
      $display("FAIL br_restart: got ok=%b pc=%0d instr=%h lit=%h required 1/0/8000/00AA",
               ok, bus.instr_pc, bus.instr, bus.literal);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_mem();
    mem[31] = 16'h8000; mem[0] = 16'h1234; mem[1] = 16'h0800;
    hold_reset();
    release_reset();
    bus.branch_valid = 1'b1;
    bus.branch_target = 5'd31;
    step();
    bus.branch_valid = 1'b0;
    bus.instr_ready = 1'b1;
    wait_valid(10, ok);
    total++;
    if (!ok || bus.instr_pc !== 5'd31 || bus.instr !== 16'h8000 || bus.literal !== 16'h1234) begin
      bad++;
      $display("FAIL wrap_push: got ok=%b pc=%0d instr=%h lit=%h required 1/31/8000/1234",
               ok, bus.instr_pc, bus.instr, bus.literal);
    end
    step();
    wait_valid(10, ok);
    total++;
    if (!ok || bus.instr_pc !== 5'd1 || bus.instr !== 16'h0800) begin
      bad++;
      $display("FAIL wrap_next: got ok=%b pc=%0d instr=%h required 1/1/0800", ok, bus.instr_pc, bus.instr);
    end
    bus.instr_ready = 1'b0;
  endtask

  // Randomized program, ready and branches; the model walks the program one
  // accepted instruction at a time.
  task automatic test_random();
    logic [AW-1:0] m_pc;
    bit            m_halted;
    int            accepts;
    logic [DW-1:0] w;
    bit            rdy, br;
    logic [AW-1:0] tgt;
    for (int i = 0; i < 32; i++) begin
      w = DW'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: w[15:11] = OP_PUSH;
        3:       w[15:11] = OP_HALT;
        default: if (w[15:11] == OP_PUSH || w[15:11] == OP_HALT) w[15:11] = 5'b00011;
      endcase
      mem[i] = w;
    end
    hold_reset();
    release_reset();
    m_pc = 5'd0;
    m_halted = 1'b0;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      total++;
      if (bus.halted !== m_halted || (m_halted && bus.instr_valid !== 1'b0)) begin
        bad++;
        $display("FAIL rnd_halt c%0d: got halted=%b valid=%b required halted=%b",
                 c, bus.halted, bus.instr_valid, m_halted);
      end
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 13) == 0);
      tgt = AW'($urandom);
      bus.instr_ready   = rdy;
      bus.branch_valid  = br;
      bus.branch_target = tgt;
      if (bus.instr_valid === 1'b1 && rdy) begin
        accepts++;
        w = mem[m_pc];
        total++;
        if (bus.instr !== w || bus.instr_pc !== m_pc ||
            (w[15:11] == OP_PUSH && bus.literal !== mem[AW'(m_pc + 1)])) begin
          bad++;
          $display("FAIL rnd_accept c%0d: got %h/%h/%0d required %h/%h/%0d", c,
                   bus.instr, bus.literal, bus.instr_pc, w, mem[AW'(m_pc + 1)], m_pc);
        end
        m_pc = (w[15:11] == OP_PUSH) ? AW'(m_pc + 2) : AW'(m_pc + 1);
        if (w[15:11] == OP_HALT) m_halted = 1'b1;
      end
      if (br) begin
        m_pc = tgt;
        m_halted = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
    end
    bus.instr_ready  = 1'b0;
    bus.branch_valid = 1'b0;
    total++;
    if (accepts < 100) begin
      bad++;
      $display("FAIL rnd_progress: got %0d accepts required at least 100", accepts);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.mem_q = '0;
    test_reset();
    test_push();
    test_program();
    test_backpressure();
    test_branch();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
